// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two result sources, the issue stage and the register-file write port.
// The master side is the pipeline (sources and issue); the slave side is the arbiter.
interface regfile_wb_arbiter_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    // Handshake rule: a port transfers in a cycle exactly when its valid and ready
    // are both 1 at the rising edge; ready never depends on that port's own valid.
    logic                         a_valid;
    logic                         a_ready;
    logic [ADDR_WIDTH-1:0]        a_rd;
    logic [DATA_WIDTH-1:0]        a_data;
    logic                         b_valid;
    logic                         b_ready;
    logic [ADDR_WIDTH-1:0]        b_rd;
    logic [DATA_WIDTH-1:0]        b_data;
    logic                         iss_valid;
    logic [ADDR_WIDTH-1:0]        iss_rd;
    logic                         we;
    logic [ADDR_WIDTH-1:0]        waddr;
    logic [DATA_WIDTH-1:0]        wdata;
    logic [(1<<ADDR_WIDTH)-1:0]   busy;
    logic                         prio_b;

    modport master (
        output a_valid, a_rd, a_data, b_valid, b_rd, b_data, iss_valid, iss_rd,
        input  a_ready, b_ready, we, waddr, wdata, busy, prio_b
    );

    modport slave (
        input  a_valid, a_rd, a_data, b_valid, b_rd, b_data, iss_valid, iss_rd,
        output a_ready, b_ready, we, waddr, wdata, busy, prio_b
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between ALU (A) and load (B) writebacks,
// with a starvation guard for B and a per-register busy scoreboard for issue stalls.
module regfile_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    regfile_wb_arbiter_if.slave bus
);
    localparam int NREG = 1 << ADDR_WIDTH;
    localparam int CW   = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         starve_q, starve_d;
    logic [CW-1:0]         starve_inc;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NREG-1:0]       busy_q, busy_d;
    logic                  a_ready_c, b_ready_c;
    logic                  a_xfer, b_xfer;

    // The favoured side is always ready; the other yields whenever the favoured one is valid.
    always_comb begin
        a_ready_c = 1'b1;
        b_ready_c = 1'b1;
        if (state_q == PRIO_A) begin
            b_ready_c = !bus.a_valid;
        end else begin
            a_ready_c = !bus.b_valid;
        end
    end

    assign a_xfer = bus.a_valid & a_ready_c;
    assign b_xfer = bus.b_valid & b_ready_c;

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        starve_inc = starve_q + 1'b1;
        case (state_q)
            PRIO_A: begin
                if (b_xfer) begin
                    starve_d = '0;
                end else if (bus.b_valid) begin
                    if (starve_inc == STARVE_LIM) begin
                        state_d  = PRIO_B;
                        starve_d = '0;
                    end else begin
                        starve_d = starve_inc;
                    end
                end
            end
            PRIO_B: begin
                if (b_xfer) begin
                    starve_d = '0;
                end
                if (b_xfer || !bus.b_valid) begin
                    state_d = PRIO_A;
                end
            end
            default: state_d = PRIO_A;
        endcase
    end

    // Writes to x0 are accepted from the source but never reach the register file.
    always_comb begin
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (a_xfer && (bus.a_rd != '0)) begin
            we_d    = 1'b1;
            waddr_d = bus.a_rd;
            wdata_d = bus.a_data;
        end else if (b_xfer && (bus.b_rd != '0)) begin
            we_d    = 1'b1;
            waddr_d = bus.b_rd;
            wdata_d = bus.b_data;
        end
    end

    // Set after clear so an issue colliding with the committing write keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (we_q) begin
            busy_d[waddr_q] = 1'b0;
        end
        if (bus.iss_valid && (bus.iss_rd != '0)) begin
            busy_d[bus.iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= PRIO_A;
            starve_q <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            busy_q   <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.a_ready = a_ready_c;
    assign bus.b_ready = b_ready_c;
    assign bus.we      = we_q;
    assign bus.waddr   = waddr_q;
    assign bus.wdata   = wdata_q;
    assign bus.busy    = busy_q;
    assign bus.prio_b  = (state_q == PRIO_B);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vectors, a cycle-level reference model compared
// every cycle, and literal expectations at the key points of each scenario.
module tb_regfile_wb_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int SM = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic cmp_en = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    regfile_wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    regfile_wb_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .STARVE_MAX(SM)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: B's waiting time in cycles; B gets one cycle of priority once it has waited SM cycles.
    logic          m_prio_b = 1'b0;
    int            m_wait   = 0;
    int            m_wait_nxt;
    logic          m_we     = 1'b0;
    logic [AW-1:0] m_waddr  = '0;
    logic [DW-1:0] m_wdata  = '0;
    logic [31:0]   m_busy   = '0;
    logic [31:0]   m_busy_nxt;
    logic          m_a_go, m_b_go;

    always_comb begin
        m_a_go = bus.a_valid && (!m_prio_b || !bus.b_valid);
        m_b_go = bus.b_valid && (m_prio_b || !bus.a_valid);
        m_wait_nxt = m_b_go ? 0 : (bus.b_valid ? m_wait + 1 : m_wait);
        m_busy_nxt = m_busy;
        if (m_we) m_busy_nxt[m_waddr] = 1'b0;
        if (bus.iss_valid && bus.iss_rd != 0) m_busy_nxt[bus.iss_rd] = 1'b1;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prio_b <= 1'b0;
            m_wait   <= 0;
            m_we     <= 1'b0;
            m_waddr  <= '0;
            m_wdata  <= '0;
            m_busy   <= '0;
        end else begin
            m_busy <= m_busy_nxt;
            if (m_wait_nxt == SM) begin
                m_prio_b <= 1'b1;
                m_wait   <= 0;
            end else begin
                m_prio_b <= 1'b0;
                m_wait   <= m_wait_nxt;
            end
            m_we <= 1'b0;
            if (m_a_go && bus.a_rd != 0) begin
                m_we <= 1'b1; m_waddr <= bus.a_rd; m_wdata <= bus.a_data;
            end else if (m_b_go && bus.b_rd != 0) begin
                m_we <= 1'b1; m_waddr <= bus.b_rd; m_wdata <= bus.b_data;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_a_ready", bus.a_ready, !m_prio_b || !bus.b_valid);
            check("m_b_ready", bus.b_ready, m_prio_b || !bus.a_valid);
            check("m_we",      bus.we,      m_we);
            check("m_waddr",   bus.waddr,   m_waddr);
            check("m_wdata",   bus.wdata,   m_wdata);
            check("m_busy",    bus.busy,    m_busy);
            check("m_prio_b",  bus.prio_b,  m_prio_b);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.a_valid = 1'b0; bus.a_rd = '0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_rd = '0; bus.b_data = '0;
        bus.iss_valid = 1'b0; bus.iss_rd = '0;
    endtask

    initial begin
        logic bgrant;
        logic [AW-1:0] prev_addr;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_we", bus.we, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_prio_b", bus.prio_b, 0);
        check("rst_a_ready", bus.a_ready, 1);
        next_cycle();
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // A only
        next_cycle();
        bus.a_valid = 1'b1; bus.a_rd = 5; bus.a_data = 32'hDEADBEEF;
        @(negedge clk); check("a_only_ready", bus.a_ready, 1);
        next_cycle(); idle();
        @(negedge clk);
        check("a_only_we", bus.we, 1);
        check("a_only_waddr", bus.waddr, 5);
        check("a_only_wdata", bus.wdata, 32'hDEADBEEF);
        next_cycle();
        @(negedge clk);
        check("a_only_we_off", bus.we, 0);
        check("a_only_wdata_hold", bus.wdata, 32'hDEADBEEF);

        // x0 drop on port B
        next_cycle();
        bus.b_valid = 1'b1; bus.b_rd = 0; bus.b_data = 32'h1234;
        @(negedge clk); check("x0_b_ready", bus.b_ready, 1);
        next_cycle(); idle();
        @(negedge clk); check("x0_we", bus.we, 0);

        // Continuous contention: B wins cycles 3 and 7
        prev_addr = '0;
        for (int i = 0; i < 9; i++) begin
            next_cycle();
            bus.a_valid = 1'b1; bus.a_rd = AW'(10 + i); bus.a_data = DW'(i);
            bus.b_valid = 1'b1; bus.b_rd = 20; bus.b_data = 32'hB0B00000;
            bgrant = (i == 3) || (i == 7);
            @(negedge clk);
            check("cont_prio_b", bus.prio_b, bgrant);
            check("cont_a_ready", bus.a_ready, !bgrant);
            check("cont_b_ready", bus.b_ready, bgrant);
            if (i > 0) begin
                check("cont_we", bus.we, 1);
                check("cont_waddr", bus.waddr, prev_addr);
            end
            prev_addr = bgrant ? AW'(20) : AW'(10 + i);
        end
        next_cycle(); idle();
        @(negedge clk); check("cont_last_waddr", bus.waddr, 18);

        // B alone writes, resetting its wait
        next_cycle();
        bus.b_valid = 1'b1; bus.b_rd = 3; bus.b_data = 32'h33;
        next_cycle(); idle();
        @(negedge clk);
        check("b_only_waddr", bus.waddr, 3);
        check("b_only_wdata", bus.wdata, 32'h33);

        // Scoreboard set then clear
        next_cycle(); bus.iss_valid = 1'b1; bus.iss_rd = 7;
        next_cycle(); idle();
        bus.a_valid = 1'b1; bus.a_rd = 7; bus.a_data = 32'h77;
        @(negedge clk); check("sb_set", bus.busy[7], 1);
        next_cycle(); idle();
        @(negedge clk);
        check("sb_we", bus.we, 1);
        check("sb_waddr", bus.waddr, 7);
        check("sb_still_busy", bus.busy[7], 1);
        next_cycle();
        @(negedge clk); check("sb_clear", bus.busy[7], 0);

        // Scoreboard set colliding with commit
        next_cycle(); bus.iss_valid = 1'b1; bus.iss_rd = 7;
        next_cycle(); idle();
        bus.a_valid = 1'b1; bus.a_rd = 7; bus.a_data = 32'h78;
        next_cycle(); idle();
        bus.iss_valid = 1'b1; bus.iss_rd = 7;
        @(negedge clk); check("sb_coll_we", bus.we, 1);
        next_cycle(); idle();
        @(negedge clk); check("sb_coll_busy", bus.busy[7], 1);
        next_cycle(); bus.iss_valid = 1'b1; bus.iss_rd = 0;
        next_cycle(); idle();
        @(negedge clk); check("sb_x0", bus.busy[0], 0);

        // Force PRIO_B, then drop b_valid
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            bus.a_valid = 1'b1; bus.a_rd = AW'(1 + i); bus.a_data = DW'(i);
            bus.b_valid = 1'b1; bus.b_rd = 21; bus.b_data = 32'h21;
        end
        next_cycle();
        bus.b_valid = 1'b0; bus.a_rd = 4;
        @(negedge clk);
        check("pb_prio_b", bus.prio_b, 1);
        check("pb_a_ready", bus.a_ready, 1);
        next_cycle(); idle();
        @(negedge clk);
        check("pb_exit", bus.prio_b, 0);
        check("pb_exit_a_ready", bus.a_ready, 1);

        // Reset mid-stream with a pending write
        next_cycle();
        bus.iss_valid = 1'b1; bus.iss_rd = 9;
        bus.a_valid = 1'b1; bus.a_rd = 12; bus.a_data = 32'h5;
        next_cycle(); idle();
        @(negedge clk);
        check("mr_we_pending", bus.we, 1);
        check("mr_busy_pending", bus.busy[9], 1);
        #2 rst_n = 1'b0;
        #1;
        check("mr_we", bus.we, 0);
        check("mr_busy", bus.busy, 0);
        check("mr_prio_b", bus.prio_b, 0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("mr_a_ready", bus.a_ready, 1);
        check("mr_prio_b_after", bus.prio_b, 0);
        check("mr_we_after", bus.we, 0);

        repeat (2) next_cycle();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
